// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encoding and
// legal-range checks on the timing parameters.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DB_PRESS = 2'd1,
    ST_HELD     = 2'd2,
    ST_DB_REL   = 2'd3
  } state_t;

  // Below two cycles the "counter reaches N-1" compare would never see a
  // distinct increment, so both timers need at least two.
  localparam int unsigned MIN_DEBOUNCE_CYCLES   = 2;
  localparam int unsigned MIN_LONG_PRESS_CYCLES = 2;

  function automatic bit debounce_cycles_ok(input int unsigned cycles);
    return cycles >= MIN_DEBOUNCE_CYCLES;
  endfunction

  function automatic bit long_press_cycles_ok(input int unsigned cycles);
    return cycles >= MIN_LONG_PRESS_CYCLES;
  endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Debounced button event bundle: level, one-cycle event pulses and the
// running press count. The producer drives it through the master modport.
interface button_debounce_if #(
  parameter int CNT_W = 8
);
  logic             level;
  logic             press_evt;
  logic             release_evt;
  logic             long_evt;
  logic [CNT_W-1:0] press_count;

  modport master (
    output level,
    output press_evt,
    output release_evt,
    output long_evt,
    output press_count
  );

  modport slave (
    input level,
    input press_evt,
    input release_evt,
    input long_evt,
    input press_count
  );
endinterface

// File: rtl/button_debounce_fsm.sv
// Debounce / long-press state machine operating on the synchronized,
// active-high button sample b_s. All event outputs are registered.
module button_debounce_fsm
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int          CNT_W             = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b_s,
  button_debounce_if.master  evt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  state_t             state_q, state_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               fired_q, fired_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               long_q, long_d;

  logic [DB_W-1:0]    db_inc;
  logic               db_hit;
  logic [HOLD_W-1:0]  hold_next;
  logic               long_hit;

  // Acceptance happens on the edge where the counter reaches N-1, so the
  // IDLE sample plus N-1 debounce samples make N stable samples in total.
  assign db_inc    = db_cnt_q + 1'b1;
  assign db_hit    = (db_inc == DB_LAST);
  assign hold_next = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
  assign long_hit  = !fired_q && (hold_next == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      fired_q   <= 1'b0;
      count_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      fired_q   <= fired_d;
      count_q   <= count_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    hold_d    = hold_q;
    fired_d   = fired_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (b_s) begin
          state_d  = ST_DB_PRESS;
          db_cnt_d = '0;
        end
      end

      ST_DB_PRESS: begin
        if (!b_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_hit) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
          press_d  = 1'b1;
          count_d  = count_q + 1'b1;
          hold_d   = '0;
          fired_d  = 1'b0;
        end else begin
          db_cnt_d = db_inc;
        end
      end

      ST_HELD: begin
        hold_d = hold_next;
        if (long_hit) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
        if (!b_s) begin
          state_d  = ST_DB_REL;
          db_cnt_d = '0;
        end
      end

      ST_DB_REL: begin
        // Hold timing keeps running through a release bounce.
        hold_d = hold_next;
        if (b_s) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
          if (long_hit) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end
        end else if (db_hit) begin
          state_d   = ST_IDLE;
          db_cnt_d  = '0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_inc;
          if (long_hit) begin
            long_d  = 1'b1;
            fired_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // The debounced level is exactly "in a pressed state", both registered.
  assign evt.level       = (state_q == ST_HELD) || (state_q == ST_DB_REL);
  assign evt.press_evt   = press_q;
  assign evt.release_evt = release_q;
  assign evt.long_evt    = long_q;
  assign evt.press_count = count_q;

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops
// reset to RESET_VAL so a reset never manufactures a spurious edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic meta;

  // NOTE: non-blocking assignments let both flops sample the pre-edge values,
  // giving a true two-stage shift instead of a single collapsed flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RESET_VAL;
      Q    <= RESET_VAL;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer top: synchronizes the raw pin, normalizes polarity
// and reports debounced level, press/release/long-press pulses and a count.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter int          CNT_W             = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  output logic             LEVEL,
  output logic             PRESS,
  output logic             RELEASE,
  output logic             LONG_PRESS,
  output logic [CNT_W-1:0] PRESS_COUNT
);

  if (!debounce_cycles_ok(DEBOUNCE_CYCLES)) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be at least %0d", MIN_DEBOUNCE_CYCLES);
  end
  if (!long_press_cycles_ok(LONG_PRESS_CYCLES)) begin : g_bad_long_press
    $error("button_debounce: LONG_PRESS_CYCLES must be at least %0d", MIN_LONG_PRESS_CYCLES);
  end

  // Raw pin level when the button is not pressed.
  localparam logic BTN_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic btn_sync;
  logic b_s;

  sync_2ff #(
    .RESET_VAL (BTN_IDLE)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (BTN),
    .Q   (btn_sync)
  );

  assign b_s = ACTIVE_LOW ? ~btn_sync : btn_sync;

  button_debounce_if #(.CNT_W(CNT_W)) evt_if ();

  button_debounce_fsm #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
    .CNT_W             (CNT_W)
  ) u_fsm (
    .clk (CLK),
    .rst (RST),
    .b_s (b_s),
    .evt (evt_if)
  );

  assign LEVEL       = evt_if.level;
  assign PRESS       = evt_if.press_evt;
  assign RELEASE     = evt_if.release_evt;
  assign LONG_PRESS  = evt_if.long_evt;
  assign PRESS_COUNT = evt_if.press_count;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected events with
// their cycle stamps; a negedge monitor pops and compares each DUT pulse.
module tb_button_debounce;

  localparam int DB = 4;
  localparam int LP = 16;
  localparam int CW = 8;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       cyc;
    logic     level;
    int       count;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b1;
  logic          level, press, rel, long_press;
  logic [CW-1:0] press_count;

  button_debounce_if #(.CNT_W(CW)) mon_if ();

  button_debounce #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .ACTIVE_LOW        (1'b1),
    .CNT_W             (CW)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .BTN         (btn),
    .LEVEL       (level),
    .PRESS       (press),
    .RELEASE     (rel),
    .LONG_PRESS  (long_press),
    .PRESS_COUNT (press_count)
  );

  assign mon_if.level       = level;
  assign mon_if.press_evt   = press;
  assign mon_if.release_evt = rel;
  assign mon_if.long_evt    = long_press;
  assign mon_if.press_count = press_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t  exp_q[$];
  ev_t  cur;
  int   checks    = 0;
  int   failures  = 0;
  int   exp_count = 0;
  logic lvl_model = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t kind, input int at);
    ev_t e;
    if (kind == EV_PRESS) exp_count = (exp_count + 1) % (1 << CW);
    e.kind  = kind;
    e.cyc   = at;
    e.level = (kind != EV_RELEASE);
    e.count = exp_count;
    exp_q.push_back(e);
  endtask

  // Called at #1 after an edge; returns at #1 after the n-th following edge.
  task automatic hold_btn(input logic v, input int n);
    btn = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_press"}, press, 0);
    check({tag, "_release"}, rel, 0);
    check({tag, "_long"}, long_press, 0);
    check({tag, "_count"}, press_count, 0);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [2:0] seen;
    seen = {mon_if.long_evt, mon_if.release_evt, mon_if.press_evt};
    for (int k = 0; k < 3; k++) begin
      if (seen[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
          cur = exp_q.pop_front();
          check("ev_kind", k, int'(cur.kind));
          check("ev_cycle", cyc, cur.cyc);
          check("ev_level", mon_if.level, cur.level);
          check("ev_count", mon_if.press_count, cur.count);
          lvl_model = cur.level;
        end
      end
    end
    check("level_track", mon_if.level, lvl_model);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    // Reset: outputs quiet during and after.
    repeat (3) @(posedge clk);
    #1;
    check_quiet("in_reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_quiet("after_reset");

    // Glitch: three low cycles fall one sample short of acceptance.
    hold_btn(1'b0, 3);
    hold_btn(1'b1, 10);
    check("glitch_level", level, 0);
    check("glitch_count", press_count, 0);

    // Wrap: 256 clean press/release pairs bring the count back to zero.
    for (int i = 0; i < 256; i++) begin
      t = cyc;
      expect_ev(EV_PRESS, t + 6);
      hold_btn(1'b0, 8);
      expect_ev(EV_RELEASE, cyc + 6);
      hold_btn(1'b1, 8);
    end
    hold_btn(1'b1, 4);
    check("wrap_count", press_count, 0);

    // Clean press: PRESS 6 cycles after the edge, count 1.
    t = cyc;
    expect_ev(EV_PRESS, t + 6);
    hold_btn(1'b0, 10);
    check("clean_count", press_count, 1);
    expect_ev(EV_RELEASE, cyc + 6);
    hold_btn(1'b1, 12);

    // Long press: one LONG_PRESS 15 cycles after PRESS.
    t = cyc;
    expect_ev(EV_PRESS, t + 6);
    expect_ev(EV_LONG, t + 21);
    hold_btn(1'b0, 40);
    expect_ev(EV_RELEASE, cyc + 6);
    hold_btn(1'b1, 12);

    // Release bounce: high 2, low 2, then high; one RELEASE after settling.
    t = cyc;
    expect_ev(EV_PRESS, t + 6);
    hold_btn(1'b0, 8);
    hold_btn(1'b1, 2);
    hold_btn(1'b0, 2);
    expect_ev(EV_RELEASE, cyc + 6);
    hold_btn(1'b1, 12);

    // Reset while held: no RELEASE, press re-debounced from IDLE.
    t = cyc;
    expect_ev(EV_PRESS, t + 6);
    hold_btn(1'b0, 10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lvl_model = 1'b0;
    exp_count = 0;
    check_quiet("mid_press_reset");
    expect_ev(EV_PRESS, cyc + 6);
    hold_btn(1'b0, 8);
    check("reset_repress_count", press_count, 1);
    expect_ev(EV_RELEASE, cyc + 6);
    hold_btn(1'b1, 12);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
